// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready flow control.
// Input register, PIPE_STAGES registered slices of the prefix network, then an output register.
module ks_adder_pipe #(
    parameter int WIDTH       = 64,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] tag_out
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int BASE   = LEVELS / PIPE_STAGES;
    localparam int EXTRA  = LEVELS % PIPE_STAGES;
    localparam int LAST   = PIPE_STAGES - 32'sd1;

    // Stage k evaluates prefix levels [first_level(k), first_level(k+1)); early stages absorb the remainder.
    function automatic int first_level(input int k);
        return (k * BASE) + ((k < EXTRA) ? k : EXTRA);
    endfunction

    function automatic logic [2*WIDTH-1:0] ks_level(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input int               d
    );
        logic [WIDTH-1:0] g_n;
        logic [WIDTH-1:0] p_n;
        for (int i = 32'sd0; i < WIDTH; i++) begin
            if (i >= d) begin
                g_n[i] = g[i] | (p[i] & g[i-d]);
                p_n[i] = p[i] & p[i-d];
            end else begin
                g_n[i] = g[i];
                p_n[i] = p[i];
            end
        end
        return {g_n, p_n};
    endfunction

    logic             advance_s;
    logic             in_v_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             cin_r;
    logic             sub_r;
    logic [TAG_W-1:0] tag_r;
    logic [WIDTH-1:0] b_eff_s;
    logic             c0_s;
    logic [WIDTH-1:0] gen0_s;
    logic [WIDTH-1:0] prop0_s;
    logic             out_valid_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic [TAG_W-1:0] tag_out_r;

    // A stalled output freezes the whole pipe, so one enable serves every stage.
    assign advance_s = ~(out_valid_r & ~out_ready);
    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign tag_out   = tag_out_r;

    // Input register: operands, mode and tag travel with their valid bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_v_r <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            cin_r  <= 1'b0;
            sub_r  <= 1'b0;
            tag_r  <= '0;
        end else if (advance_s) begin
            in_v_r <= in_valid;
            if (in_valid) begin
                a_r   <= a;
                b_r   <= b;
                cin_r <= cin;
                sub_r <= sub;
                tag_r <= tag_in;
            end
        end
    end

    // Per-bit generate/propagate after the subtract-mode inversion of b and cin.
    always_comb begin
        b_eff_s = sub_r ? ~b_r : b_r;
        c0_s    = cin_r ^ sub_r;
        gen0_s  = a_r & b_eff_s;
        prop0_s = a_r ^ b_eff_s;
    end

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        logic             src_v_s;
        logic [WIDTH-1:0] src_g_s;
        logic [WIDTH-1:0] src_p_s;
        logic [WIDTH-1:0] src_x_s;
        logic             src_c0_s;
        logic [TAG_W-1:0] src_tag_s;
        logic [WIDTH-1:0] nxt_g_s;
        logic [WIDTH-1:0] nxt_p_s;
        logic             pf_v_r;
        logic [WIDTH-1:0] pf_g_r;
        logic [WIDTH-1:0] pf_p_r;
        logic [WIDTH-1:0] pf_x_r;
        logic             pf_c0_r;
        logic [TAG_W-1:0] pf_tag_r;

        if (k == 0) begin : g_head
            assign src_v_s   = in_v_r;
            assign src_g_s   = gen0_s;
            assign src_p_s   = prop0_s;
            assign src_x_s   = prop0_s;
            assign src_c0_s  = c0_s;
            assign src_tag_s = tag_r;
        end else begin : g_body
            assign src_v_s   = g_stage[k-1].pf_v_r;
            assign src_g_s   = g_stage[k-1].pf_g_r;
            assign src_p_s   = g_stage[k-1].pf_p_r;
            assign src_x_s   = g_stage[k-1].pf_x_r;
            assign src_c0_s  = g_stage[k-1].pf_c0_r;
            assign src_tag_s = g_stage[k-1].pf_tag_r;
        end

        // Prefix levels owned by this stage; span doubles each level.
        always_comb begin
            nxt_g_s = src_g_s;
            nxt_p_s = src_p_s;
            for (int l = 32'sd0; l < LEVELS; l++) begin
                {nxt_g_s, nxt_p_s} = ((l >= first_level(k)) && (l < first_level(k + 32'sd1)))
                                   ? ks_level(nxt_g_s, nxt_p_s, 32'sd1 <<< l)
                                   : {nxt_g_s, nxt_p_s};
            end
        end

        // Stage register for the partial prefix result.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pf_v_r   <= 1'b0;
                pf_g_r   <= '0;
                pf_p_r   <= '0;
                pf_x_r   <= '0;
                pf_c0_r  <= 1'b0;
                pf_tag_r <= '0;
            end else if (advance_s) begin
                pf_v_r   <= src_v_s;
                pf_g_r   <= nxt_g_s;
                pf_p_r   <= nxt_p_s;
                pf_x_r   <= src_x_s;
                pf_c0_r  <= src_c0_s;
                pf_tag_r <= src_tag_s;
            end
        end
    end

    logic             fin_v_s;
    logic [WIDTH-1:0] fin_g_s;
    logic [WIDTH-1:0] fin_p_s;
    logic [WIDTH-1:0] fin_x_s;
    logic             fin_c0_s;
    logic [TAG_W-1:0] fin_tag_s;
    logic [WIDTH-1:0] carry_s;
    logic [WIDTH-1:0] res_sum_s;
    logic             res_cout_s;
    logic             res_ovf_s;

    assign fin_v_s   = g_stage[LAST].pf_v_r;
    assign fin_g_s   = g_stage[LAST].pf_g_r;
    assign fin_p_s   = g_stage[LAST].pf_p_r;
    assign fin_x_s   = g_stage[LAST].pf_x_r;
    assign fin_c0_s  = g_stage[LAST].pf_c0_r;
    assign fin_tag_s = g_stage[LAST].pf_tag_r;

    // Carry into bit i is the group (G,P) over [i-1:0] combined with the carry-in.
    always_comb begin
        carry_s    = {fin_g_s[WIDTH-2:0] | (fin_p_s[WIDTH-2:0] & {(WIDTH-1){fin_c0_s}}), fin_c0_s};
        res_sum_s  = fin_x_s ^ carry_s;
        res_cout_s = fin_g_s[WIDTH-1] | (fin_p_s[WIDTH-1] & fin_c0_s);
        res_ovf_s  = res_cout_s ^ carry_s[WIDTH-1];
    end

    // Output register: result fields only change when a valid result lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            tag_out_r   <= '0;
        end else if (advance_s) begin
            out_valid_r <= fin_v_s;
            if (fin_v_s) begin
                sum_r     <= res_sum_s;
                cout_r    <= res_cout_s;
                ovf_r     <= res_ovf_s;
                tag_out_r <= fin_tag_s;
            end
        end
    end
endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: three configurations run side by side, each checked against an
// arithmetic reference model with a result queue, plus hand-computed directed cases.
module tb_ks_adder_pipe;
    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used to measure latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int W  = (c == 0) ? 64 : ((c == 1) ? 8 : 128);
        localparam int P  = (c == 0) ? 2 : ((c == 1) ? 1 : 7);
        localparam int TW = 4;

        logic          rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
        logic [W-1:0]  a, b, sum;
        logic [TW-1:0] tag_in, tag_out;
        bit            done = 1'b0;
        bit            rnd_ready = 1'b0;

        ks_adder_pipe #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(TW)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .a(a), .b(b), .cin(cin), .sub(sub), .tag_in(tag_in),
            .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
            .cout(cout), .ovf(ovf), .tag_out(tag_out)
        );

        logic [W-1:0]  q_sum[$];
        logic          q_cout[$];
        logic          q_ovf[$];
        logic [TW-1:0] q_tag[$];
        int            q_acc[$];
        int            q_stl[$];
        bit            q_seen[$];
        logic [W-1:0]  last_sum = '0;
        logic          last_cout = 1'b0;
        logic          last_ovf = 1'b0;
        logic [TW-1:0] last_tag = '0;
        int            stall_cnt = 0;

        // Returns {ovf, cout, sum} from plain integer arithmetic.
        function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic ci, input logic s);
            logic [W-1:0] ye;
            logic         ce;
            logic [W:0]   t;
            logic         v;
            ye = s ? ~y : y;
            ce = s ? ~ci : ci;
            t  = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
            v  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
            return {v, t};
        endfunction

        // Scoreboard: record accepted operations, compare every visible output cycle.
        always @(negedge clk) begin
            logic [W+1:0] e;
            if (rst) begin
                q_sum.delete(); q_cout.delete(); q_ovf.delete(); q_tag.delete();
                q_acc.delete(); q_stl.delete(); q_seen.delete();
                last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0; last_tag = '0;
            end else begin
                check($sformatf("cfg%0d in_ready", c), 256'(in_ready), 256'(!(out_valid && !out_ready)));
                check($sformatf("cfg%0d spurious_out", c), 256'(out_valid && (q_sum.size() == 0)), 256'(1'b0));
                if (out_valid && (q_sum.size() != 0)) begin
                    check($sformatf("cfg%0d sum", c), 256'(sum), 256'(q_sum[0]));
                    check($sformatf("cfg%0d cout", c), 256'(cout), 256'(q_cout[0]));
                    check($sformatf("cfg%0d ovf", c), 256'(ovf), 256'(q_ovf[0]));
                    check($sformatf("cfg%0d tag", c), 256'(tag_out), 256'(q_tag[0]));
                    if (!q_seen[0]) begin
                        q_seen[0] = 1'b1;
                        if (q_stl[0] == stall_cnt)
                            check($sformatf("cfg%0d latency", c), 256'(cyc - q_acc[0]), 256'(P + 2));
                    end
                    last_sum = sum; last_cout = cout; last_ovf = ovf; last_tag = tag_out;
                    if (out_ready) begin
                        void'(q_sum.pop_front()); void'(q_cout.pop_front()); void'(q_ovf.pop_front());
                        void'(q_tag.pop_front()); void'(q_acc.pop_front()); void'(q_stl.pop_front());
                        void'(q_seen.pop_front());
                    end
                end else if (!out_valid) begin
                    check($sformatf("cfg%0d hold", c), 256'({sum, cout, ovf, tag_out}),
                          256'({last_sum, last_cout, last_ovf, last_tag}));
                end
                if (out_valid && !out_ready) stall_cnt++;
                if (in_valid && in_ready) begin
                    e = model(a, b, cin, sub);
                    q_sum.push_back(e[W-1:0]); q_cout.push_back(e[W]); q_ovf.push_back(e[W+1]);
                    q_tag.push_back(tag_in); q_acc.push_back(cyc); q_stl.push_back(stall_cnt);
                    q_seen.push_back(1'b0);
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            #1;
        endtask

        task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                            input logic xs, input logic [TW-1:0] xt);
            int guard;
            guard = 0;
            a = xa; b = xb; cin = xc; sub = xs; tag_in = xt; in_valid = 1'b1;
            while (!in_ready && (guard < 200)) begin
                tick();
                guard++;
            end
            if (guard >= 200) check($sformatf("cfg%0d send_timeout", c), 256'(in_ready), 256'(1'b1));
            tick();
            in_valid = 1'b0;
        endtask

        task automatic directed(input string nm, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                input logic xc, input logic xs, input logic [TW-1:0] xt,
                                input logic [W-1:0] es, input logic ec, input logic eo);
            send(xa, xb, xc, xs, xt);
            repeat (P + 1) tick();
            check($sformatf("cfg%0d %s valid", c, nm), 256'(out_valid), 256'(1'b1));
            check($sformatf("cfg%0d %s sum", c, nm), 256'(sum), 256'(es));
            check($sformatf("cfg%0d %s cout", c, nm), 256'(cout), 256'(ec));
            check($sformatf("cfg%0d %s ovf", c, nm), 256'(ovf), 256'(eo));
            check($sformatf("cfg%0d %s tag", c, nm), 256'(tag_out), 256'(xt));
        endtask

        task automatic rand_op(input int i);
            logic [127:0] ra;
            logic [127:0] rb;
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 7))
                0: ra = '1;
                1: rb = '1;
                2: rb = '0;
                default: ;
            endcase
            send(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), TW'(i));
        endtask

        task automatic drain();
            int guard;
            guard = 0;
            while ((q_sum.size() != 0) && (guard < 100)) begin
                tick();
                guard++;
            end
            tick();
            check($sformatf("cfg%0d drain_empty", c), 256'(q_sum.size()), 256'(0));
        endtask

        initial begin
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
            a = '0; b = '0; cin = 1'b0; sub = 1'b0; tag_in = '0;
            tick();
            tick();
            check($sformatf("cfg%0d rst out_valid", c), 256'(out_valid), 256'(1'b0));
            check($sformatf("cfg%0d rst outputs", c), 256'({sum, cout, ovf, tag_out}), 256'(0));
            rst = 1'b0;
            check($sformatf("cfg%0d in_ready_after_rst", c), 256'(in_ready), 256'(1'b1));
            directed("carry_wrap", '1, '0, 1'b1, 1'b0, 4'd3, '0, 1'b1, 1'b0);
            directed("pos_ovf", {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b0, 4'd5,
                     {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1);
            directed("sub_neg", W'(5), W'(7), 1'b0, 1'b1, 4'd6, {{(W-1){1'b1}}, 1'b0}, 1'b0, 1'b0);
            for (int i = 0; i < 100; i++) rand_op(i);
            drain();
            rnd_ready = 1'b1;
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                rand_op(i);
            end
            rnd_ready = 1'b0;
            out_ready = 1'b1;
            drain();
            rand_op(1);
            rand_op(2);
            rand_op(3);
            rst = 1'b1;
            #1;
            check($sformatf("cfg%0d midrst out_valid", c), 256'(out_valid), 256'(1'b0));
            check($sformatf("cfg%0d midrst outputs", c), 256'({sum, cout, ovf, tag_out}), 256'(0));
            tick();
            rst = 1'b0;
            repeat (12) tick();
            directed("after_rst", W'(100), W'(23), 1'b1, 1'b0, 4'd9, W'(124), 1'b0, 1'b0);
            drain();
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && (t < 40000)) begin
            @(posedge clk);
            t++;
        end
        check("all_configs_done", 256'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 256'(3'b111));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ks_adder_pipe.md
KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width; SHALL be a power of two, 8 to 128.
REQ-002 Parameter PIPE_STAGES, default 2, register stages inserted in the prefix network; SHALL be 1 to log2(WIDTH).
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried alongside each operation.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 tag_in  input  TAG_W  sideband; returned unchanged with its result.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry-out; for subtract, inverted borrow-out.
REQ-016 ovf  output  1  signed two's-complement overflow.
REQ-017 tag_out  output  TAG_W  tag of the current result.

Function
REQ-018 Add: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-019 Subtract: {cout,sum} SHALL equal a + ~b + ~cin, i.e. a - b - cin; cout=1 means no borrow.
REQ-020 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, after the sub-mode inversion of b.
REQ-021 Sum SHALL be computed with a Kogge-Stone parallel-prefix network: per-bit generate/propagate, log2(WIDTH) prefix levels, sum = p XOR carry.
REQ-022 Prefix levels SHALL be split across PIPE_STAGES register stages as evenly as possible; earlier stages take the extra level when the split is uneven.
REQ-023 An input register stage SHALL capture a, b, cin, sub and tag_in; an output register stage SHALL drive sum, cout, ovf and tag_out.
REQ-024 Latency from an accepted input (in_valid & in_ready) to the matching out_valid SHALL be exactly PIPE_STAGES+2 cycles when no stall occurs.
REQ-025 Throughput SHALL be one operation per cycle while out_ready=1.
REQ-026 Each stage SHALL carry a valid bit; tag, mode and operands SHALL travel with that valid bit.
REQ-027 Stall: when out_valid=1 and out_ready=0, all stages SHALL hold their contents, in_ready SHALL be 0, and no input is accepted.
REQ-028 in_ready SHALL equal NOT(out_valid AND NOT out_ready) and SHALL be combinational from out_ready.
REQ-029 Bubbles (in_valid=0) SHALL propagate as invalid stages; results SHALL never reorder, duplicate or drop.
REQ-030 While out_valid=0, sum, cout, ovf and tag_out SHALL hold their last values.
REQ-031 An input offered while in_ready=0 SHALL be ignored; the source must hold it until accepted.

Reset
REQ-032 While rst=1, all stage valid bits, out_valid, sum, cout, ovf and tag_out SHALL be 0, regardless of clk.
REQ-033 After reset, in_ready SHALL be 1.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after rst deasserts.
REQ-035 The first input accepted on the first rising edge after rst deasserts SHALL complete normally.

Verification (WIDTH=64, PIPE_STAGES=2, latency 4)
REQ-036 Input a=FFFF_FFFF_FFFF_FFFF, b=0, cin=1, sub=0, tag=3 -> four cycles later: sum=0, cout=1, ovf=0, tag_out=3.
REQ-037 Input a=7FFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0 -> sum=8000_0000_0000_0000, cout=0, ovf=1; input a=5, b=7, cin=0, sub=1 -> sum=FFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-038 Back-to-back stream of 100 random operations with tags 0..15 cycling, out_ready=1 -> every result matches the reference model, in order, one per cycle after the initial 4-cycle fill.
REQ-039 Random out_ready toggling (50%) during a 200-operation stream -> no loss or duplication, in_ready=0 exactly when out_valid=1 and out_ready=0, and outputs stable while stalled.
REQ-040 Pulse rst for one cycle with three operations in flight -> all outputs 0 immediately and out_valid stays 0 until a new input completes four cycles after acceptance.
REQ-041 Repeat REQ-036 and REQ-038 with WIDTH=8 and PIPE_STAGES=1 (latency 3), and with WIDTH=128 and PIPE_STAGES=7 (latency 9) -> same correctness, with latency matching REQ-024.
